div_result_queue: RTL and testbench
===================================

Name: div_result_queue

Overview:
- Output stage placed directly downstream of the 10-bit restoring-divider datapath and its controller.
- Captures each finished quotient, together with a divide-by-zero flag, on the controller's one-cycle done strobe.
- Buffers results in a small first-word-fall-through FIFO.
- Presents results to the consumer over a valid/ready handshake, so the divider can start its next operation without waiting on the consumer.

Parameters:
- WIDTH, 10, quotient width; matches the divider Q output.
- DEPTH, 4, number of FIFO entries; must be a power of two and at least 2.
- DROP_W, 8, width of the saturating dropped-result counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- sclr  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
- done  input  1  one-cycle strobe from the divider controller; a result is present this cycle.
- q_in  input  WIDTH  quotient from the divider datapath; sampled only when done=1.
- dbz_in  input  1  B_is_zero status from the datapath; sampled with q_in.
- res_ready  input  1  consumer accepts the head entry this cycle.
- res_valid  output  1  FIFO non-empty; the head entry is presented.
- res_data  output  WIDTH  head quotient; 0 when empty.
- res_dbz  output  1  head divide-by-zero flag; 0 when empty.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- drop_cnt  output  DROP_W  number of results lost because the FIFO was full; saturates.

Behaviour:
- Reset (sclr=1, asynchronous): rd/wr pointers=0, count=0, drop_cnt=0, res_valid=0, res_data=0, res_dbz=0, full=0. Storage array contents need not be cleared.
- Reset mid-operation: queued results are discarded. The first done after sclr deasserts is stored at entry 0.
- Entry format: {dbz, q}, WIDTH+1 bits.
- Push: done=1 and (not full, or pop this cycle) -> write {dbz_in, q_in} at wr_ptr, wr_ptr+1 modulo DEPTH.
- Pop: res_valid=1 and res_ready=1 -> rd_ptr+1 modulo DEPTH.
- res_ready while empty: ignored; no state change.
- Count update: +1 on push only, -1 on pop only, unchanged on push and pop together.
- First-word-fall-through:
  - res_valid = (count != 0).
  - res_data/res_dbz are driven combinationally from the entry at rd_ptr, gated to 0 when empty.
  - A result pushed in cycle N is visible at the output in cycle N+1 (latency 1).
  - Write-through to the output in the same cycle is not allowed.
- Full, push with simultaneous pop: both are accepted; count stays at DEPTH. The popped entry is the old head, never the incoming value.
- Full, push without pop: the incoming result is dropped. drop_cnt increments unless it is at 2^DROP_W-1, where it holds. Storage and pointers are unchanged.
- Empty, push with res_ready=1: push only; res_valid rises next cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full/empty are derived from count, not from pointer equality.
- res_data must be stable while res_valid=1 and res_ready=0.
- done asserted on consecutive cycles: each cycle is a separate push. The block does not edge-detect.
- No combinational path from res_ready to any output except through registered state.

Test Plan:
- Reset, then done=1 with q_in=10'h155, dbz_in=0 for one cycle -> next cycle res_valid=1, res_data=10'h155, res_dbz=0, count=1. Assert res_ready=1 -> following cycle res_valid=0, res_data=0, count=0.
- With res_ready=0, push 10'h001, 10'h002, 10'h003, 10'h004 -> full=1, count=4. Push 10'h3FF -> drop_cnt=1, count=4. Drain -> outputs 1, 2, 3, 4 in order; 10'h3FF never appears.
- At full, push 10'h0AA with res_ready=1 in the same cycle -> head 10'h001 is popped, count stays 4. After draining, the order is 2, 3, 4, 0AA.
- Push q_in=0, dbz_in=1 -> res_valid=1, res_data=0, res_dbz=1. Pop -> res_dbz=0 once empty.
- Hold full with res_ready=0 and push 300 times -> drop_cnt saturates at 255, with no wrap to 0.
- Push 3 entries, assert sclr asynchronously between clock edges -> res_valid, count and drop_cnt go to 0 before the next clk edge. The next push 10'h123 appears as the head one cycle later.

Source files
------------

// File: rtl/div_result_queue.sv
// Result stage behind the restoring divider. It captures {dbz, quotient} on the
// done strobe and presents the entries through a first-word-fall-through valid/ready queue.
module div_result_queue #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     sclr,
    input  logic                     done,
    input  logic [WIDTH-1:0]         q_in,
    input  logic                     dbz_in,
    input  logic                     res_ready,
    output logic                     res_valid,
    output logic [WIDTH-1:0]         res_data,
    output logic                     res_dbz,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef logic [WIDTH:0] entry_t;  // {dbz, q}

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    entry_t          head;
    logic            push;
    logic            pop;
    logic            drop;

    assign res_valid = (count != '0);
    assign full      = (count == FULL_CNT);

    // A full queue can still accept a push when the head leaves in the same cycle.
    // The write then lands in the slot being vacated, and the popped value is the old head.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        pop  = res_valid && res_ready;
        push = done && (!full || pop);
        drop = done && full && !pop;
    end

    // The head comes straight out of storage, so a write shows up one cycle later.
    // When the queue is empty, both output fields are forced to zero.
    assign head     = mem[rd_ptr];
    assign res_data = res_valid ? head[WIDTH-1:0] : '0;
    assign res_dbz  = res_valid ? head[WIDTH]     : 1'b0;

    // NOTE: storage has no reset on purpose. The pointers and count decide what is
    // valid, and a reset-free array can map onto plain RAM or flops without reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {dbz_in, q_in};
    end

    // NOTE: every sequential update uses non-blocking assignment. All registers
    // then sample the same pre-edge values, which avoids evaluation-order races.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_div_result_queue.sv
// Scoreboard bench for div_result_queue. A queue-based reference model tracks accepted
// results, and a negedge monitor compares every DUT output against that model.
module tb_div_result_queue;

    localparam int WIDTH  = 10;
    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic               clk = 1'b0;
    logic               sclr = 1'b1;
    logic               done = 1'b0;
    logic [WIDTH-1:0]   q_in = '0;
    logic               dbz_in = 1'b0;
    logic               res_ready = 1'b0;
    logic               res_valid;
    logic [WIDTH-1:0]   res_data;
    logic               res_dbz;
    logic [2:0]         count;
    logic               full;
    logic [DROP_W-1:0]  drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH:0] exp_q[$];
    int             drop_exp = 0;

    div_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk       (clk),
        .sclr      (sclr),
        .done      (done),
        .q_in      (q_in),
        .dbz_in    (dbz_in),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_dbz   (res_dbz),
        .count     (count),
        .full      (full),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of at most DEPTH results. The head leaves when the
    // consumer is ready, and a result is accepted only if the queue has room after that pop.
    always @(posedge clk or posedge sclr) begin
        if (sclr) begin
            exp_q.delete();
            drop_exp = 0;
        end else begin
            automatic bit do_pop = (exp_q.size() > 0) && res_ready;
            if (do_pop)
                void'(exp_q.pop_front());
            if (done) begin
                if (exp_q.size() < DEPTH)
                    exp_q.push_back({dbz_in, q_in});
                else if (drop_exp < DROP_MAX)
                    drop_exp++;
            end
        end
    end

    // The monitor samples away from the active edge.
    always @(negedge clk) begin
        automatic logic [WIDTH:0] hd = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("res_valid", 32'(res_valid), 32'(exp_q.size() > 0));
        check("count",     32'(count),     32'(exp_q.size()));
        check("full",      32'(full),      32'(exp_q.size() == DEPTH));
        check("drop_cnt",  32'(drop_cnt),  32'(drop_exp));
        check("res_data",  32'(res_data),  32'(hd[WIDTH-1:0]));
        check("res_dbz",   32'(res_dbz),   32'(hd[WIDTH]));
    end

    // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
    task automatic step(input logic d, input logic [WIDTH-1:0] q, input logic z, input logic r);
        done = d; q_in = q; dbz_in = z; res_ready = r;
        @(posedge clk);
        #1;
        done = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 sclr = 1'b0;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_data",  32'(res_data),  32'd0);

        // Single push, then pop it one cycle later.
        step(1, 10'h155, 0, 0);
        check("t1_valid", 32'(res_valid), 32'd1);
        check("t1_data",  32'(res_data),  32'h155);
        check("t1_count", 32'(count),     32'd1);
        step(0, 0, 0, 1);
        check("t1_empty", 32'(res_valid), 32'd0);
        check("t1_data0", 32'(res_data),  32'd0);

        // Fill the queue, push once more so that result is dropped, then drain in order.
        for (int i = 1; i <= 4; i++) step(1, WIDTH'(i), 0, 0);
        check("t2_full",  32'(full),  32'd1);
        check("t2_count", 32'(count), 32'd4);
        step(1, 10'h3FF, 0, 0);
        check("t2_drop",  32'(drop_cnt), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            check("t2_order", 32'(res_data), 32'(i));
            step(0, 0, 0, 1);
        end

        // Push and pop together while full.
        for (int i = 1; i <= 4; i++) step(1, WIDTH'(i), 0, 0);
        step(1, 10'h0AA, 0, 1);
        check("t3_count", 32'(count),    32'd4);
        check("t3_head",  32'(res_data), 32'd2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Divide-by-zero flag.
        step(1, 10'h000, 1, 0);
        check("t4_dbz",  32'(res_dbz),  32'd1);
        check("t4_data", 32'(res_data), 32'd0);
        step(0, 0, 0, 1);
        check("t4_dbz0", 32'(res_dbz),  32'd0);

        // The drop counter saturates.
        for (int i = 1; i <= 4; i++) step(1, WIDTH'(i), 0, 0);
        for (int i = 0; i < 300; i++) step(1, WIDTH'($urandom), 0, 0);
        check("t5_sat", 32'(drop_cnt), 32'd255);

        // Asynchronous reset in the middle of the queue's operation.
        sclr = 1'b1; #2 sclr = 1'b0;
        for (int i = 0; i < 3; i++) step(1, WIDTH'(10 + i), 0, 0);
        #2 sclr = 1'b1;
        #1;
        check("t6_valid", 32'(res_valid), 32'd0);
        check("t6_count", 32'(count),     32'd0);
        check("t6_drop",  32'(drop_cnt),  32'd0);
        @(negedge clk);
        sclr = 1'b0;
        step(1, 10'h123, 0, 0);
        check("t6_head",  32'(res_data), 32'h123);
        step(0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            automatic int bias = (i / 250) % 4;
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, WIDTH'($urandom),
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) < bias) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 1);
        check("end_empty", 32'(res_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
